// File: rtl/bcd_pkg.sv
// Shared types and constants for the digit-serial BCD adder/subtractor.
package bcd_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } bcd_state_t;

   localparam int BCD_DIGIT_W = 4;
   localparam int BCD_MAX     = 9;
   localparam int BCD_CORR    = 6;

   function automatic logic bcd_digit_bad(input logic [BCD_DIGIT_W-1:0] d);
      return d > BCD_DIGIT_W'(BCD_MAX);
   endfunction

endpackage

// File: rtl/bcd_digit_adder.sv
// One decimal digit of addition with the >9 -> +6 correction; purely combinational.
module bcd_digit_adder
   import bcd_pkg::*;
(
   input  logic [BCD_DIGIT_W-1:0] a,
   input  logic [BCD_DIGIT_W-1:0] b,
   input  logic                   cin,
   output logic [BCD_DIGIT_W-1:0] digit,
   output logic                   cout
);

   logic [BCD_DIGIT_W:0] t;

   always_comb begin
      t = {1'b0, a} + {1'b0, b} + {{BCD_DIGIT_W{1'b0}}, cin};
      if (t > (BCD_DIGIT_W + 1)'(BCD_MAX)) begin
         // Four-bit wrap of t+6 is exactly the corrected digit.
         digit = t[BCD_DIGIT_W-1:0] + BCD_DIGIT_W'(BCD_CORR);
         cout  = 1'b1;
      end else begin
         digit = t[BCD_DIGIT_W-1:0];
         cout  = 1'b0;
      end
   end

endmodule

// File: rtl/bcd_seq_adder.sv
// Digit-serial packed-BCD adder/subtractor, one digit per clock, LSD first,
// with valid/ready handshakes on input and output.
module bcd_seq_adder
   import bcd_pkg::*;
#(
   parameter int DIGITS = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [4*DIGITS-1:0]       a,
   input  logic [4*DIGITS-1:0]       b,
   input  logic                      sub,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [4*DIGITS-1:0]       sum,
   output logic                      cout,
   output logic                      err
);

   localparam int W     = BCD_DIGIT_W * DIGITS;
   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

   bcd_state_t       state_q, state_d;
   logic [W-1:0]     a_q, a_d;
   logic [W-1:0]     b_q, b_d;
   logic             sub_q, sub_d;
   logic             c_q, c_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [W-1:0]     sum_q, sum_d;
   logic             cout_q, cout_d;
   logic             err_q, err_d;
   logic             in_ready_q, in_ready_d;
   logic             out_valid_q, out_valid_d;

   logic [BCD_DIGIT_W-1:0] a_dig [DIGITS];
   logic [BCD_DIGIT_W-1:0] b_dig [DIGITS];
   logic [DIGITS-1:0]      in_bad;

   logic [BCD_DIGIT_W-1:0] cur_a, cur_bd, dig_out;
   logic                   dig_cout;

   genvar gi;
   generate
      for (gi = 0; gi < DIGITS; gi++) begin : g_dig
         assign a_dig[gi]  = a_q[gi*BCD_DIGIT_W +: BCD_DIGIT_W];
         assign b_dig[gi]  = b_q[gi*BCD_DIGIT_W +: BCD_DIGIT_W];
         assign in_bad[gi] = bcd_digit_bad(a[gi*BCD_DIGIT_W +: BCD_DIGIT_W])
                           | bcd_digit_bad(b[gi*BCD_DIGIT_W +: BCD_DIGIT_W]);
      end
   endgenerate

   // Subtraction is A + nines-complement(B) + 1; the +1 enters as the initial carry.
   assign cur_a  = a_dig[idx_q];
   assign cur_bd = sub_q ? (BCD_DIGIT_W'(BCD_MAX) - b_dig[idx_q]) : b_dig[idx_q];

   bcd_digit_adder u_digit (
      .a     (cur_a),
      .b     (cur_bd),
      .cin   (c_q),
      .digit (dig_out),
      .cout  (dig_cout)
   );

   always_comb begin
      state_d     = state_q;
      a_d         = a_q;
      b_d         = b_q;
      sub_d       = sub_q;
      c_d         = c_q;
      idx_d       = idx_q;
      sum_d       = sum_q;
      cout_d      = cout_q;
      err_d       = err_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;

      case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_d        = a;
               b_d        = b;
               sub_d      = sub;
               c_d        = sub;
               idx_d      = '0;
               err_d      = |in_bad;
               in_ready_d = 1'b0;
               state_d    = RUN;
            end
         end
         RUN: begin
            for (int i = 0; i < DIGITS; i++) begin
               if (idx_q == IDX_W'(i)) begin
                  sum_d[i*BCD_DIGIT_W +: BCD_DIGIT_W] = dig_out;
               end
            end
            c_d   = dig_cout;
            idx_d = idx_q + 1'b1;
            if (idx_q == LAST_IDX) begin
               cout_d      = dig_cout;
               idx_d       = '0;
               out_valid_d = 1'b1;
               state_d     = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               in_ready_d  = 1'b1;
               state_d     = IDLE;
            end
         end
         default: begin
            out_valid_d = 1'b0;
            in_ready_d  = 1'b1;
            state_d     = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         a_q         <= '0;
         b_q         <= '0;
         sub_q       <= 1'b0;
         c_q         <= 1'b0;
         idx_q       <= '0;
         sum_q       <= '0;
         cout_q      <= 1'b0;
         err_q       <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         b_q         <= b_d;
         sub_q       <= sub_d;
         c_q         <= c_d;
         idx_q       <= idx_d;
         sum_q       <= sum_d;
         cout_q      <= cout_d;
         err_q       <= err_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign sum       = sum_q;
   assign cout      = cout_q;
   assign err       = err_q;

endmodule

// File: tb/tb_bcd_seq_adder.sv
// Randomized self-checking bench for bcd_seq_adder (DIGITS=4 and DIGITS=1 instances)
// against an integer-arithmetic decimal model.
module tb_bcd_seq_adder;

   localparam int D = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic          in_valid, in_ready, sub, out_valid, out_ready, cout, err;
   logic [15:0]   a, b, sum;
   logic          in_valid1, in_ready1, sub1, out_valid1, out_ready1, cout1, err1;
   logic [3:0]    a1, b1, sum1;

   int checks = 0;
   int errors = 0;

   bcd_seq_adder #(.DIGITS(D)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum), .cout(cout), .err(err)
   );

   bcd_seq_adder #(.DIGITS(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
      .a(a1), .b(b1), .sub(sub1), .out_valid(out_valid1), .out_ready(out_ready1),
      .sum(sum1), .cout(cout1), .err(err1)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic int bcd2int(input logic [15:0] v);
      int r = 0;
      for (int i = 3; i >= 0; i--) r = r * 10 + int'(v[i*4 +: 4]);
      return r;
   endfunction

   function automatic logic [15:0] int2bcd(input int v);
      logic [15:0] r;
      for (int i = 0; i < 4; i++) begin
         r[i*4 +: 4] = 4'(v % 10);
         v = v / 10;
      end
      return r;
   endfunction

   function automatic logic has_bad(input logic [15:0] v);
      logic bad = 1'b0;
      for (int i = 0; i < 4; i++) if (v[i*4 +: 4] > 4'd9) bad = 1'b1;
      return bad;
   endfunction

   // Decimal reference: add, or ten's complement A - B + 10^4; cout is the 10^4 overflow.
   task automatic model(input logic [15:0] x, input logic [15:0] y, input logic s,
                        output logic [15:0] es, output logic ec);
      int r;
      r  = s ? (bcd2int(x) - bcd2int(y) + 10000) : (bcd2int(x) + bcd2int(y));
      ec = (r >= 10000);
      es = int2bcd(r % 10000);
   endtask

   task automatic run_op(input logic [15:0] x, input logic [15:0] y, input logic s, input int stall);
      int n;
      logic [15:0] es;
      logic ec, eb;
      model(x, y, s, es, ec);
      eb = has_bad(x) | has_bad(y);
      n = 0;
      while (!in_ready && n < 50) begin @(negedge clk); n++; end
      chk("in_ready_idle", 32'(in_ready), 32'd1);
      a = x; b = y; sub = s; in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      chk("in_ready_run", 32'(in_ready), 32'd0);
      n = 0;
      while (!out_valid && n < 20) begin @(negedge clk); n++; end
      chk("latency", 32'(n), 32'(D));
      chk("err", 32'(err), 32'(eb));
      if (!eb) begin
         chk("sum", 32'(sum), 32'(es));
         chk("cout", 32'(cout), 32'(ec));
      end
      for (int i = 0; i < stall; i++) begin
         in_valid = ~in_valid;
         a = 16'($urandom);
         b = 16'($urandom);
         @(negedge clk);
         chk("hold_valid", 32'(out_valid), 32'd1);
         chk("hold_ready", 32'(in_ready), 32'd0);
         chk("hold_err", 32'(err), 32'(eb));
         if (!eb) begin
            chk("hold_sum", 32'(sum), 32'(es));
            chk("hold_cout", 32'(cout), 32'(ec));
         end
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("ret_valid", 32'(out_valid), 32'd0);
      chk("ret_ready", 32'(in_ready), 32'd1);
      $display("op a=%04h b=%04h sub=%0d stall=%0d -> sum=%04h cout=%0d err=%0d (exp sum=%04h cout=%0d err=%0d)",
               x, y, s, stall, sum, cout, err, es, ec, eb);
   endtask

   task automatic run_op1(input logic [3:0] x, input logic [3:0] y, input logic s);
      int n, r;
      r = s ? (int'(x) - int'(y) + 10) : (int'(x) + int'(y));
      chk("d1_in_ready", 32'(in_ready1), 32'd1);
      a1 = x; b1 = y; sub1 = s; in_valid1 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid1 = 1'b0;
      n = 0;
      while (!out_valid1 && n < 10) begin @(negedge clk); n++; end
      chk("d1_latency", 32'(n), 32'd1);
      chk("d1_sum", 32'(sum1), 32'(r % 10));
      chk("d1_cout", 32'(cout1), 32'(r >= 10));
      out_ready1 = 1'b1;
      @(negedge clk);
      out_ready1 = 1'b0;
      @(negedge clk);
      $display("op1 a=%0d b=%0d sub=%0d -> sum=%0d cout=%0d (exp sum=%0d cout=%0d)",
               x, y, s, sum1, cout1, r % 10, r >= 10);
   endtask

   initial begin
      in_valid = 0; a = 0; b = 0; sub = 0; out_ready = 0;
      in_valid1 = 0; a1 = 0; b1 = 0; sub1 = 0; out_ready1 = 0;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_sum", 32'(sum), 32'd0);
      chk("rst_cout", 32'(cout), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      run_op(16'h1234, 16'h5678, 1'b0, 0);
      run_op(16'h9999, 16'h0001, 1'b0, 0);
      run_op(16'h5000, 16'h1234, 1'b1, 0);
      run_op(16'h0001, 16'h0002, 1'b1, 0);
      run_op(16'h00A0, 16'h0001, 1'b0, 0);
      run_op(16'h4321, 16'h1111, 1'b0, 5);

      // Abandon an operation while digit 2 is being computed.
      a = 16'h1234; b = 16'h5678; sub = 1'b0; in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_ready", 32'(in_ready), 32'd1);
      chk("mid_rst_sum", 32'(sum), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("post_rst_valid", 32'(out_valid), 32'd0);
         chk("post_rst_ready", 32'(in_ready), 32'd1);
      end
      run_op(16'h0045, 16'h0055, 1'b0, 0);

      for (int k = 0; k < 30; k++) begin
         logic [15:0] x, y;
         x = int2bcd(int'($urandom_range(0, 9999)));
         y = int2bcd(int'($urandom_range(0, 9999)));
         if ($urandom_range(0, 9) == 0) x[$urandom_range(0, 3)*4 +: 4] = 4'($urandom_range(10, 15));
         run_op(x, y, 1'($urandom), int'($urandom_range(0, 2)));
      end

      run_op1(4'd9, 4'd9, 1'b0);
      run_op1(4'd3, 4'd7, 1'b1);
      for (int k = 0; k < 8; k++)
         run_op1(4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)), 1'($urandom));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

endmodule
